trng_sampler: RTL

- Downstream consumer of the NAND-based RS-latch entropy cell; takes its raw `Q` output as `raw_in`.
- Synchronizes the raw bit into the `clk` domain and samples it at a programmable rate.
- Runs a repetition-count health test and von Neumann debiasing, then packs debiased bits into WIDTH-bit words.
- Offers the words to the host logic through a valid/ready interface.

---
 rtl/trng_sampler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/trng_sampler.sv
// trng_sampler: synchronizes the raw RS-latch entropy bit, samples it at a
// programmable rate, runs a repetition-count health test and von Neumann
// debiasing, and packs the debiased bits into WIDTH-bit words offered over
// a valid/ready interface.
module trng_sampler #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DIV_W       = 8,
    parameter int REP_LIMIT   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             raw_in,
    input  logic [DIV_W-1:0] sample_div,
    input  logic             vn_bypass,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [WIDTH-1:0] rd_data,
    output logic             fault
);

    localparam int BCNT_W = $clog2(WIDTH + 1);
    localparam int REP_W  = $clog2(REP_LIMIT + 1);
    localparam logic [BCNT_W-1:0] BCNT_FULL = BCNT_W'(WIDTH);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(REP_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        FULL,
        FAULT
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   s_bit;
    logic [DIV_W-1:0]       div_cnt;
    logic                   tick;
    logic                   prev_bit;
    logic [REP_W-1:0]       rep_cnt;
    logic [REP_W-1:0]       rep_next;
    logic                   rep_hit;
    logic                   pend;
    logic                   a_bit;
    logic                   emit;
    logic                   emit_bit;
    logic [WIDTH-1:0]       acc;
    logic [BCNT_W-1:0]      bcnt;

    assign s_bit = sync[SYNC_STAGES-1];

    // Metastability synchronizer for the asynchronous entropy bit; always runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw_in};
        end
    end

    // Sample strobe, health-test next count and von Neumann bit extraction.
    always_comb begin
        tick     = en && (state != IDLE) && (div_cnt == sample_div);
        rep_next = REP_W'(1);
        if ((rep_cnt != '0) && (s_bit == prev_bit)) begin
            rep_next = (rep_cnt == REP_MAX) ? rep_cnt : rep_cnt + REP_W'(1);
        end
        rep_hit  = tick && (rep_next == REP_MAX);
        emit     = 1'b0;
        emit_bit = s_bit;
        if (tick) begin
            if (vn_bypass) begin
                emit = 1'b1;
            end else if (pend) begin
                emit     = (a_bit != s_bit);
                emit_bit = a_bit;
            end
        end
    end

    // Control FSM with divider, health test, debias pairing, accumulator and
    // output register; priority is en=0, then fault, then transfer, then accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            div_cnt  <= '0;
            prev_bit <= 1'b0;
            rep_cnt  <= '0;
            fault    <= 1'b0;
            pend     <= 1'b0;
            a_bit    <= 1'b0;
            acc      <= '0;
            bcnt     <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (!en) begin
            state    <= IDLE;
            div_cnt  <= '0;
            prev_bit <= 1'b0;
            rep_cnt  <= '0;
            fault    <= 1'b0;
            pend     <= 1'b0;
            a_bit    <= 1'b0;
            acc      <= '0;
            bcnt     <= '0;
            if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end
        end else begin
            if (state != IDLE) begin
                div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            end

            if (tick) begin
                prev_bit <= s_bit;
                rep_cnt  <= rep_next;
                if (rep_hit) begin
                    fault <= 1'b1;
                end
                if (vn_bypass) begin
                    pend <= 1'b0;
                end else begin
                    pend <= ~pend;
                    if (!pend) begin
                        a_bit <= s_bit;
                    end
                end
            end

            // A load in FULL below overrides this clear in the same cycle.
            if (rd_valid && rd_ready) begin
                rd_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    state <= COLLECT;
                end
                COLLECT: begin
                    if (rep_hit) begin
                        state <= FAULT;
                        acc   <= '0;
                        bcnt  <= '0;
                    end else if (emit && (bcnt < BCNT_FULL)) begin
                        acc  <= {acc[WIDTH-2:0], emit_bit};
                        bcnt <= bcnt + BCNT_W'(1);
                        if (bcnt == BCNT_FULL - BCNT_W'(1)) begin
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (rep_hit) begin
                        state <= FAULT;
                        acc   <= '0;
                        bcnt  <= '0;
                    end else if (!rd_valid || rd_ready) begin
                        rd_data  <= acc;
                        rd_valid <= 1'b1;
                        bcnt     <= '0;
                        state    <= COLLECT;
                    end
                end
                FAULT: begin
                    acc  <= '0;
                    bcnt <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
